// File: rtl/sigdel_mod.sv
// Second-order 1-bit sigma-delta DAC modulator. Accepts one offset-binary
// sample every OSR clocks over a ready/valid port and drives a bitstream pin.
module sigdel_mod #(
  parameter int BITLEN = 16,
  parameter int OSR    = 64,
  parameter int ACCW   = BITLEN + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [BITLEN-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dac_out,
  output logic              underrun
);

  localparam int CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int SUMW  = ACCW + 2;

  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [BITLEN-1:0]      X_MID    = {1'b1, {(BITLEN-1){1'b0}}};
  localparam logic signed [SUMW-1:0] SAT_MAX  = {3'b000, {(ACCW-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN  = {3'b111, {(ACCW-1){1'b0}}};
  localparam logic signed [SUMW-1:0] FB_POS   =
    {{(SUMW-BITLEN){1'b0}}, 1'b1, {(BITLEN-1){1'b0}}};
  localparam logic signed [SUMW-1:0] FB_NEG   = -FB_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        osr_cnt, osr_cnt_d;
  logic [BITLEN-1:0]       x_reg, x_reg_d;
  logic signed [ACCW-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
  logic signed [ACCW-1:0]  acc1_n, acc2_n;
  logic                    dac_d, underrun_d;
  logic signed [SUMW-1:0]  x_ext, fb, sum1, sum2;
  logic                    slot;

  // Clamp a widened sum back into the integrator range.
  function automatic logic signed [ACCW-1:0] sat(input logic signed [SUMW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[ACCW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[ACCW-1:0];
    else                  sat = v[ACCW-1:0];
  endfunction

  // Loop filter: two saturating integrators with 1-bit feedback, computed two
  // bits wider than the accumulators so the pre-clamp sums never wrap.
  always_comb begin
    x_ext  = {{(SUMW-BITLEN){~x_reg[BITLEN-1]}}, ~x_reg[BITLEN-1], x_reg[BITLEN-2:0]};
    fb     = dac_out ? FB_POS : FB_NEG;
    sum1   = {{2{acc1_q[ACCW-1]}}, acc1_q} + x_ext - fb;
    acc1_n = sat(sum1);
    sum2   = {{2{acc2_q[ACCW-1]}}, acc2_q} + {{2{acc1_n[ACCW-1]}}, acc1_n} - fb;
    acc2_n = sat(sum2);
  end

  assign slot = (osr_cnt == CNT_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    osr_cnt_d    = osr_cnt;
    x_reg_d      = x_reg;
    acc1_d       = acc1_q;
    acc2_d       = acc2_q;
    dac_d        = dac_out;
    underrun_d   = underrun;
    sample_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        acc1_d    = '0;
        acc2_d    = '0;
        osr_cnt_d = '0;
        dac_d     = ~dac_out;
        if (enable) begin
          state_d    = PRIME;
          underrun_d = 1'b0;
        end
      end

      PRIME: begin
        sample_ready = 1'b1;
        dac_d        = ~dac_out;
        if (!enable) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          x_reg_d   = sample_in;
          osr_cnt_d = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        sample_ready = slot;
        if (!enable) begin
          // Disable wins over a sample offered in the same cycle.
          state_d   = IDLE;
          acc1_d    = '0;
          acc2_d    = '0;
          osr_cnt_d = '0;
          dac_d     = ~dac_out;
        end else begin
          acc1_d    = acc1_n;
          acc2_d    = acc2_n;
          dac_d     = (acc2_n >= 0);
          osr_cnt_d = slot ? '0 : osr_cnt + 1'b1;
          if (slot) begin
            if (sample_valid) x_reg_d    = sample_in;
            else              underrun_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; the combinational blocks above use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      osr_cnt  <= '0;
      x_reg    <= X_MID;
      acc1_q   <= '0;
      acc2_q   <= '0;
      dac_out  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      osr_cnt  <= osr_cnt_d;
      x_reg    <= x_reg_d;
      acc1_q   <= acc1_d;
      acc2_q   <= acc2_d;
      dac_out  <= dac_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_sigdel_mod.sv
// Self-checking bench for sigdel_mod: directed scenarios plus random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_sigdel_mod;

  localparam int BITLEN = 16;
  localparam int OSR    = 64;
  localparam int ACCW   = 20;
  localparam longint HALF = 64'sd32768;
  localparam longint AMAX = (64'sd1 <<< (ACCW-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACCW-1));

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [BITLEN-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready, dac_out, underrun;

  int n_assert = 0;
  int n_fail   = 0;
  int ones     = 0;
  int rdy_cnt  = 0;
  int sat_hits = 0;
  bit mon_sat  = 1'b0;

  sigdel_mod #(.BITLEN(BITLEN), .OSR(OSR), .ACCW(ACCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_out      (dac_out),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: signed sample value, integer integrators, clamp by limits.
  typedef enum {M_IDLE, M_PRIME, M_RUN} mstate_t;
  mstate_t m_state;
  int      m_cnt;
  longint  m_a1, m_a2;
  int      m_x;
  bit      m_dac, m_under;

  function automatic longint clamp(input longint v);
    return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
  endfunction

  function automatic bit m_ready();
    return (m_state == M_PRIME) || (m_state == M_RUN && m_cnt == OSR - 1);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_a1 = 0; m_a2 = 0;
    m_x = 32768; m_dac = 1'b0; m_under = 1'b0;
  endtask

  task automatic model_edge();
    longint xs, fb;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      M_IDLE: begin
        m_a1 = 0; m_a2 = 0; m_cnt = 0; m_dac = !m_dac;
        if (enable) begin m_state = M_PRIME; m_under = 1'b0; end
      end
      M_PRIME: begin
        m_dac = !m_dac;
        if (!enable) m_state = M_IDLE;
        else if (sample_valid) begin m_x = int'(sample_in); m_cnt = 0; m_state = M_RUN; end
      end
      default: begin
        if (!enable) begin
          m_state = M_IDLE; m_a1 = 0; m_a2 = 0; m_cnt = 0; m_dac = !m_dac;
        end else begin
          xs    = longint'(m_x) - HALF;
          fb    = m_dac ? HALF : -HALF;
          m_a1  = clamp(m_a1 + xs - fb);
          m_a2  = clamp(m_a2 + m_a1 - fb);
          m_dac = (m_a2 >= 0);
          if (m_cnt == OSR - 1) begin
            m_cnt = 0;
            if (sample_valid) m_x = int'(sample_in);
            else              m_under = 1'b1;
          end else begin
            m_cnt++;
          end
        end
      end
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", name, $time, obs, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_assert++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dac_out", dac_out, m_dac);
    check("sample_ready", sample_ready, m_ready());
    check("underrun", underrun, m_under);
    if (dac_out) ones++;
    if (sample_ready) rdy_cnt++;
    if (mon_sat && (dut.acc1_q == 20'sh7FFFF || dut.acc1_q == 20'sh80000 ||
                    dut.acc2_q == 20'sh7FFFF || dut.acc2_q == 20'sh80000)) sat_hits++;
  endtask

  task automatic restart(input logic [15:0] val);
    enable = 1'b0; sample_valid = 1'b1; sample_in = val;
    tick(); tick();
    enable = 1'b1;
    tick(); tick();
  endtask

  task automatic wait_slot(input string name);
    int k = 0;
    while (!(m_state == M_RUN && m_ready()) && k < 200) begin tick(); k++; end
    check({name, "_slot_found"}, (k < 200), 1'b1);
  endtask

  initial begin
    int k;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_dac", dac_out, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", sample_ready, 1'b0);
    check("rst_x_reg", dut.x_reg, 16'h8000);
    tick(); tick();
    rst = 1'b0;
    tick(); check("idle_toggle0", dac_out, 1'b1);
    tick(); check("idle_toggle1", dac_out, 1'b0);

    // Midscale input.
    restart(16'h8000);
    repeat (256) tick();
    ones = 0;
    repeat (4096) tick();
    check_range("midscale_ones", ones, 2046, 2050);
    check("midscale_underrun", underrun, 1'b0);

    // Full-scale extremes.
    restart(16'hFFFF);
    repeat (256) tick();
    ones = 0;
    repeat (4096) tick();
    check_range("fullscale_ones", ones, 4090, 4096);

    restart(16'h0000);
    repeat (256) tick();
    ones = 0;
    repeat (4096) tick();
    check_range("zeroscale_ones", ones, 0, 6);

    // Three-quarter density, integrators must stay clear of the rails.
    restart(16'hC000);
    repeat (256) tick();
    ones = 0; sat_hits = 0; mon_sat = 1'b1;
    repeat (8192) tick();
    mon_sat = 1'b0;
    check_range("density_ones", ones, 6103, 6185);
    check("density_no_sat", sat_hits, 0);

    // Handshake cadence, underrun on a withheld sample.
    rdy_cnt = 0;
    repeat (128) tick();
    check("ready_per_128", rdy_cnt, 2);
    wait_slot("withhold");
    sample_valid = 1'b0; sample_in = 16'h1234;
    tick();
    check("withhold_underrun", underrun, 1'b1);
    check("withhold_x_hold", dut.x_reg, 16'hC000);
    sample_valid = 1'b1;
    k = 1;
    while (!sample_ready && k < 200) begin tick(); k++; end
    check("ready_return_cycles", k, 64);
    enable = 1'b0;
    tick();
    check("underrun_sticky_idle", underrun, 1'b1);
    check("idle_acc1_clear", dut.acc1_q, 0);
    enable = 1'b1;
    tick();
    check("underrun_clear_prime", underrun, 1'b0);

    // Disable on the same edge as an offered sample.
    sample_in = 16'hC000; sample_valid = 1'b1;
    tick(); tick();
    wait_slot("disable");
    sample_in = 16'h1234; enable = 1'b0;
    tick();
    check("disable_x_hold", dut.x_reg, 16'hC000);
    check("disable_acc1", dut.acc1_q, 0);
    check("disable_acc2", dut.acc2_q, 0);
    check("disable_osr_cnt", dut.osr_cnt, 0);
    tick();
    check("disable_stays_idle", sample_ready, 1'b0);

    // Random traffic against the model.
    enable = 1'b1;
    for (int seg = 0; seg < 30; seg++) begin
      sample_in = 16'($urandom);
      for (int c = 0; c < int'($urandom_range(40, 200)); c++) begin
        sample_valid = ($urandom_range(0, 7) != 0);
        enable       = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 1) == 1) sample_in = 16'($urandom);
        tick();
      end
    end

    // Asynchronous reset in the middle of RUN, between clock edges.
    restart(16'hA000);
    sample_valid = 1'b0;
    repeat (100) tick();
    check("pre_reset_underrun", underrun, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_dac", dac_out, 1'b0);
    check("midrun_rst_underrun", underrun, 1'b0);
    check("midrun_rst_ready", sample_ready, 1'b0);
    check("midrun_rst_x_reg", dut.x_reg, 16'h8000);
    check("midrun_rst_acc1", dut.acc1_q, 0);
    check("midrun_rst_acc2", dut.acc2_q, 0);
    check("midrun_rst_osr_cnt", dut.osr_cnt, 0);
    model_reset();
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick(); check("post_rst_dac0", dac_out, 1'b1);
    tick(); check("post_rst_dac1", dac_out, 1'b0);
    tick(); check("post_rst_dac2", dac_out, 1'b1);
    tick(); check("post_rst_dac3", dac_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sigdel_mod.md
SIGDEL_MOD -- requirements
Module: sigdel_mod

Interface
REQ-001 The block SHALL have parameter BITLEN, default 16, giving the input sample width in bits.
REQ-002 The block SHALL have parameter OSR, default 64, giving clocks per input sample (oversampling ratio); legal values are 2..1024.
REQ-003 The block SHALL have parameter ACCW, default BITLEN+4, giving the signed integrator width in bits.
REQ-004 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port enable, input, 1: modulator run request.
REQ-007 Port sample_in, input, BITLEN: unsigned offset-binary sample from the upstream sine ROM stage.
REQ-008 Port sample_valid, input, 1: sample_in is valid this cycle.
REQ-009 Port sample_ready, output, 1: the block accepts sample_in at this rising edge.
REQ-010 Port dac_out, output, 1: registered 1-bit sigma-delta bitstream to the pin.
REQ-011 Port underrun, output, 1: sticky flag set when a sample slot passed without sample_valid.

Function
REQ-012 The block SHALL have three states: IDLE, PRIME and RUN.
REQ-013 IDLE: integrators=0, osr_cnt=0, sample_ready=0, and dac_out SHALL toggle every cycle (midscale pattern).
REQ-014 IDLE -> PRIME SHALL occur on the first cycle enable=1.
REQ-015 PRIME: sample_ready=1 combinationally; on a cycle with sample_valid=1 the block SHALL latch x_reg <= sample_in, set osr_cnt=0 and enter RUN.
REQ-016 PRIME: dac_out SHALL continue toggling.
REQ-017 RUN: osr_cnt SHALL increment by 1 each cycle and wrap from OSR-1 to 0.
REQ-018 RUN: sample_ready SHALL be 1 only when osr_cnt==OSR-1, and SHALL be 0 otherwise.
REQ-019 RUN, osr_cnt==OSR-1, sample_valid=1: x_reg SHALL load sample_in at that edge; the new value is used from the next cycle.
REQ-020 RUN, osr_cnt==OSR-1, sample_valid=0: x_reg SHALL hold its value, underrun SHALL set to 1, and modulation SHALL continue.
REQ-021 sample_valid while sample_ready=0 SHALL be ignored, with no state change.
REQ-022 Signed input: x = {~x_reg[BITLEN-1], x_reg[BITLEN-2:0]}, sign-extended to ACCW.
REQ-023 Feedback: fb = +2^(BITLEN-1) when the current dac_out=1, else -2^(BITLEN-1).
REQ-024 Each RUN cycle: acc1_n = sat(acc1 + x - fb).
REQ-025 Each RUN cycle: acc2_n = sat(acc2 + acc1_n - fb).
REQ-026 Each RUN cycle: dac_out <= (acc2_n >= 0).
REQ-027 sat() SHALL clamp to [-2^(ACCW-1), 2^(ACCW-1)-1]; intermediate sums SHALL be computed at ACCW+2 bits so no wrap-around occurs.
REQ-028 dac_out latency: a new x_reg value SHALL affect dac_out 1 cycle after it is loaded.
REQ-029 enable=0 in PRIME or RUN SHALL return the block to IDLE at the next edge and clear the integrators; x_reg SHALL hold its value.
REQ-030 underrun SHALL clear only on rst or on the IDLE -> PRIME transition.
REQ-031 Simultaneous enable=0 and sample acceptance: enable SHALL win, so the block enters IDLE and the sample is not loaded.

Reset
REQ-032 While rst=1, all state SHALL clear immediately regardless of clk: state=IDLE, acc1=acc2=0, osr_cnt=0, x_reg=2^(BITLEN-1), dac_out=0, underrun=0, sample_ready=0.
REQ-033 After rst falls, dac_out SHALL begin toggling on the first clk edge, provided enable=0.
REQ-034 rst asserted mid-RUN SHALL abort the block to the REQ-032 values with no completion of the current sample period.

Verification
REQ-035 Reset: assert rst asynchronously mid-RUN between edges -> all outputs reach the REQ-032 values before the next edge; after release with enable=0, dac_out = 1,0,1,0...
REQ-036 Midscale: enable=1, feed 0x8000 every slot, OSR=64 -> over cycles 256..4351, the count of ones is 2048±2; underrun stays 0.
REQ-037 Extremes: feed 0xFFFF -> ones >= 4090 of 4096 cycles after a 256-cycle settle; feed 0x0000 -> ones <= 6 of 4096.
REQ-038 Density: feed 0xC000 -> ones fraction 0.75±0.005 over 8192 cycles; the integrators never saturate.
REQ-039 Handshake: sample_ready pulses exactly once every 64 cycles in RUN. Withhold sample_valid in one slot -> underrun=1 on the next cycle, x_reg unchanged, and sample_ready returns 64 cycles later. Toggle enable 0 -> 1 -> underrun clears on entry to PRIME.
REQ-040 Disable at a slot: enable=0 on the same cycle as an accepted sample -> state=IDLE next cycle, x_reg keeps the old value, integrators=0.
